// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//
// Memory-stage load/store unit. Takes the M-stage control bundle and ALU
// result, runs a req/ready handshake with data memory, stalls the pipeline
// while the memory is busy, and registers the M/W stage (controls plus the
// extended load data) for the writeback mux.
//
// Parameters
//   TIMEOUT_CYCLES  max WAIT cycles before a bus error is raised (0 = never)
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   RegWriteM, ResultSrcM,     M-stage controls (ResultSrcM 2'b01 = load)
//   MemWriteM, ForwardValMuxM
//   Funct3M                    access size / sign
//   ALUResultM                 effective address / ALU result
//   WriteDataM                 store data
//   RdM, PCPlus4M              destination register, PC+4
//   mem_req/we/addr/wdata/be   request to data memory (word-aligned address,
//                              lane-replicated write data, byte enables)
//   mem_ready, mem_rdata       memory accept/complete and read data
//   StallM                     hold F/D/E/M registers
//   MisalignM                  one-cycle pulse: misaligned/illegal access dropped
//   BusErrM                    one-cycle pulse: memory timeout, access dropped
//   *W outputs                 registered W-stage copies
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic        ForwardValMuxM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic        ForwardValMuxW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Request captured when the memory does not answer in the first cycle
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_we;
  logic [2:0]    r_f3;
  logic [1:0]    r_off;
  logic [CW-1:0] r_cnt;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic w_is_load;
  logic w_is_store;
  logic w_access;
  logic w_f3_legal;
  logic w_align_ok;
  logic w_misaligned;
  logic w_aligned_access;
  logic w_timeout;
  logic w_complete;
  logic w_drop;

  assign w_is_store = MemWriteM;
  assign w_is_load  = (ResultSrcM == 2'b01);
  assign w_access   = w_is_store | w_is_load;

  // Stores take priority, so the unsigned load sizes are illegal whenever
  // MemWriteM is set, even if ResultSrcM also says load.
  always_comb begin
    w_f3_legal = 1'b0;
    case (Funct3M)
      3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
      3'b100, 3'b101:         w_f3_legal = ~w_is_store;
      default:                w_f3_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_align_ok = 1'b0;
    case (Funct3M[1:0])
      2'b00:   w_align_ok = 1'b1;
      2'b01:   w_align_ok = ~ALUResultM[0];
      2'b10:   w_align_ok = (ALUResultM[1:0] == 2'b00);
      default: w_align_ok = 1'b0;
    endcase
  end

  assign w_misaligned     = w_access & ~(w_f3_legal & w_align_ok);
  assign w_aligned_access = w_access & ~w_misaligned;

  // ---------------------------------------------------------------------------
  // Byte lanes: enables and replicated store data from the live M inputs,
  // and a per-lane view of the read data for extraction.
  // ---------------------------------------------------------------------------
  logic [3:0]  w_be_byte;
  logic [31:0] w_wdata_byte;
  logic [7:0]  w_rlane [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_be_byte[gi]            = (ALUResultM[1:0] == 2'(gi));
    assign w_wdata_byte[8*gi +: 8]  = WriteDataM[7:0];
    assign w_rlane[gi]              = mem_rdata[8*gi +: 8];
  end

  logic [3:0]  w_be_m;
  logic [31:0] w_wdata_m;

  always_comb begin
    w_be_m    = 4'b0000;
    w_wdata_m = WriteDataM;
    case (Funct3M[1:0])
      2'b00: begin
        w_be_m    = w_be_byte;
        w_wdata_m = w_wdata_byte;
      end
      2'b01: begin
        w_be_m    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        w_wdata_m = {2{WriteDataM[15:0]}};
      end
      2'b10: begin
        w_be_m    = 4'b1111;
        w_wdata_m = WriteDataM;
      end
      default: begin
        w_be_m    = 4'b0000;
        w_wdata_m = WriteDataM;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Timeout: the counter holds the number of WAIT cycles already spent.
  // Ready in the timeout cycle still completes the access.
  // ---------------------------------------------------------------------------
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == S_WAIT) &&
                     !mem_ready && (r_cnt == TO_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_aligned_access && !mem_ready) w_state_next = S_WAIT;
      S_WAIT: if (mem_ready || w_timeout)         w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs. Everything is forced low while reset is held so that a
  // request in flight is withdrawn at once, not on the next edge.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'b0000;
    StallM    = 1'b0;
    MisalignM = 1'b0;
    BusErrM   = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (w_misaligned) begin
            MisalignM = 1'b1;
          end else if (w_aligned_access) begin
            mem_req   = 1'b1;
            mem_we    = w_is_store;
            mem_addr  = {ALUResultM[31:2], 2'b00};
            mem_wdata = w_wdata_m;
            mem_be    = w_be_m;
            StallM    = ~mem_ready;
          end
        end
        S_WAIT: begin
          mem_req   = 1'b1;
          mem_we    = r_we;
          mem_addr  = r_addr;
          mem_wdata = r_wdata;
          mem_be    = r_be;
          StallM    = ~mem_ready & ~w_timeout;
          BusErrM   = w_timeout;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture and WAIT cycle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_be    <= 4'b0000;
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_off   <= 2'b00;
      r_cnt   <= '0;
    end else begin
      if (r_state == S_IDLE && w_state_next == S_WAIT) begin
        r_addr  <= {ALUResultM[31:2], 2'b00};
        r_wdata <= w_wdata_m;
        r_be    <= w_be_m;
        r_we    <= w_is_store;
        r_f3    <= Funct3M;
        r_off   <= ALUResultM[1:0];
      end
      if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load data extraction (size/offset from the live inputs in IDLE, from the
  // captured request in WAIT)
  // ---------------------------------------------------------------------------
  logic [2:0]  w_f3_x;
  logic [1:0]  w_off_x;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [31:0] w_load_data;

  assign w_f3_x  = (r_state == S_WAIT) ? r_f3  : Funct3M;
  assign w_off_x = (r_state == S_WAIT) ? r_off : ALUResultM[1:0];
  assign w_byte  = w_rlane[w_off_x];
  assign w_half  = w_off_x[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_ext = 32'h0;
    case (w_f3_x)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b010:  w_ext = mem_rdata;
      3'b100:  w_ext = {24'h0, w_byte};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = 32'h0;
    endcase
  end

  assign w_complete  = mem_req & mem_ready;
  assign w_load_data = (w_complete && !mem_we) ? w_ext : 32'h0;
  assign w_drop      = MisalignM | BusErrM;

  // ---------------------------------------------------------------------------
  // M/W pipeline register. A stall inserts a bubble (write and result select
  // cleared) while the data fields keep their last value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteW      <= 1'b0;
      ResultSrcW     <= 2'b00;
      ForwardValMuxW <= 1'b0;
      ALUResultW     <= 32'h0;
      ReadDataW      <= 32'h0;
      RdW            <= 5'd0;
      PCPlus4W       <= 32'h0;
    end else if (StallM) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
    end else begin
      RegWriteW      <= RegWriteM & ~w_drop;
      ResultSrcW     <= ResultSrcM;
      ForwardValMuxW <= ForwardValMuxM;
      ALUResultW     <= ALUResultM;
      ReadDataW      <= w_load_data;
      RdW            <= RdM;
      PCPlus4W       <= PCPlus4M;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic        ForwardValMuxM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic        ForwardValMuxW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ForwardValMuxM(ForwardValMuxM), .Funct3M(Funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ForwardValMuxW(ForwardValMuxW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic        fv;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } w_t;

  w_t          exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc = 32'h0;

  // Drive one M-stage instruction
  task automatic set_m(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    pc             = pc + 32'd4;
    RegWriteM      = rw;
    ResultSrcM     = rs;
    MemWriteM      = mw;
    Funct3M        = f3;
    ALUResultM     = a;
    WriteDataM     = wd;
    RdM            = rd;
    ForwardValMuxM = rd[0];
    PCPlus4M       = pc;
  endtask

  task automatic set_idle();
    RegWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    MemWriteM  = 1'b0;
  endtask

  // Expected W contents for the instruction currently driven on the M inputs
  function automatic w_t mk(input logic rw, input logic [1:0] rs, input logic [31:0] rdata);
    w_t e;
    e.rw    = rw;
    e.rs    = rs;
    e.fv    = ForwardValMuxM;
    e.alu   = ALUResultM;
    e.rdata = rdata;
    e.rd    = RdM;
    e.pc4   = PCPlus4M;
    return e;
  endfunction

  function automatic w_t w_obs();
    w_t o;
    o.rw    = RegWriteW;
    o.rs    = ResultSrcW;
    o.fv    = ForwardValMuxW;
    o.alu   = ALUResultW;
    o.rdata = ReadDataW;
    o.rd    = RdW;
    o.pc4   = PCPlus4W;
    return o;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    set_idle();
    Funct3M = 3'b000; ALUResultM = 32'h0; WriteDataM = 32'h0; RdM = 5'd0;
    ForwardValMuxM = 1'b0; PCPlus4M = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (w_obs() !== '0) begin
      errors++; $display("FAIL reset_w got %h expected %h", w_obs(), 105'h0);
    end
    checks++;
    if ({mem_req, StallM, MisalignM, BusErrM} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b expected 0000", {mem_req, StallM, MisalignM, BusErrM});
    end
    set_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 5'd1);
    #1;
    checks++;
    if ({mem_req, StallM} !== 2'b00) begin
      errors++; $display("FAIL reset_req_gated got %b expected 00", {mem_req, StallM});
    end
    @(negedge clk);
    reset = 1'b0;
    set_idle();
    $display("txn reset: W cleared, request gated");
  endtask

  task automatic test_lw();
    w_t e;
    @(negedge clk);
    set_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    exp_q.push_back(mk(1'b1, 2'b01, 32'hDEADBEEF));
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, StallM, MisalignM, BusErrM} !==
        {1'b1, 1'b0, 32'h100, 4'hF, 3'b000}) begin
      errors++; $display("FAIL lw_bus got req=%b we=%b addr=%h be=%b stall=%b expected req=1 we=0 addr=00000100 be=1111 stall=0",
                         mem_req, mem_we, mem_addr, mem_be, StallM);
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (w_obs() !== e) begin
      errors++; $display("FAIL lw_w got %h expected %h", w_obs(), e);
    end
    $display("txn LW addr=00000100 ReadDataW=%h", ReadDataW);
  endtask

  task automatic test_load_stall();
    w_t   e;
    int   stalls;
    bit   done;
    logic st;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    for (int p = 0; p < 2; p++) begin
      f3     = (p == 0) ? 3'b000 : 3'b100;
      exp_rd = (p == 0) ? 32'hFFFFFF80 : 32'h00000080;
      @(negedge clk);
      set_m(1'b1, 2'b01, 1'b0, f3, 32'h103, 32'h0, 5'd7);
      mem_ready = 1'b0; mem_rdata = 32'h80123456;
      exp_q.push_back(mk(1'b1, 2'b01, exp_rd));
      stalls = 0; done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
        if (k > 0) @(negedge clk);
        mem_ready = (k == 3);
        #1;
        checks++;
        if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h100, 4'b1000}) begin
          errors++; $display("FAIL lb_bus got req=%b addr=%h be=%b expected req=1 addr=00000100 be=1000",
                             mem_req, mem_addr, mem_be);
        end
        st = StallM;
        @(posedge clk); #1;
        if (st) begin
          stalls++;
          checks++;
          if ({RegWriteW, ResultSrcW} !== 3'b000) begin
            errors++; $display("FAIL lb_bubble got %b expected 000", {RegWriteW, ResultSrcW});
          end
        end else begin
          done = 1'b1;
          e = exp_q.pop_front();
          checks++;
          if (w_obs() !== e) begin
            errors++; $display("FAIL lb_w got %h expected %h", w_obs(), e);
          end
        end
      end
      checks++;
      if (!done || stalls != 3) begin
        errors++; $display("FAIL lb_stalls got done=%0d stalls=%0d expected done=1 stalls=3", done, stalls);
      end
      $display("txn %s addr=00000103 stalls=%0d ReadDataW=%h", (p == 0) ? "LB" : "LBU", stalls, ReadDataW);
    end
  endtask

  task automatic test_store();
    w_t e;
    logic [2:0]  f3_t [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] a_t  [3] = '{32'h201, 32'h202, 32'h204};
    logic [31:0] d_t  [3] = '{32'hCAFE12EF, 32'h1234ABCD, 32'h89ABCDEF};
    logic [3:0]  be_t [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] wd_t [3] = '{32'hEFEFEFEF, 32'hABCDABCD, 32'h89ABCDEF};
    logic [31:0] ma_t [3] = '{32'h200, 32'h200, 32'h204};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_m(1'b0, 2'b00, 1'b1, f3_t[i], a_t[i], d_t[i], 5'(i + 2));
      mem_ready = 1'b1; mem_rdata = 32'h77777777;
      exp_q.push_back(mk(1'b0, 2'b00, 32'h0));
      #1;
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, StallM} !==
          {1'b1, 1'b1, ma_t[i], be_t[i], wd_t[i], 1'b0}) begin
        errors++; $display("FAIL store_bus[%0d] got req=%b we=%b addr=%h be=%b wdata=%h stall=%b expected req=1 we=1 addr=%h be=%b wdata=%h stall=0",
                           i, mem_req, mem_we, mem_addr, mem_be, mem_wdata, StallM, ma_t[i], be_t[i], wd_t[i]);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (w_obs() !== e) begin
        errors++; $display("FAIL store_w[%0d] got %h expected %h", i, w_obs(), e);
      end
      $display("txn STORE f3=%b addr=%h be=%b wdata=%h", f3_t[i], a_t[i], mem_be, mem_wdata);
    end
  endtask

  task automatic test_misalign();
    w_t e;
    logic [1:0]  rs_t [5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01};
    logic        mw_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3_t [5] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100};
    logic [31:0] a_t  [5] = '{32'h101, 32'h103, 32'h100, 32'h202, 32'h100};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_m(1'b1, rs_t[i], mw_t[i], f3_t[i], a_t[i], 32'h55AA55AA, 5'(i + 10));
      mem_ready = 1'b1; mem_rdata = 32'h12345678;
      exp_q.push_back(mk(1'b0, rs_t[i], 32'h0));
      #1;
      checks++;
      if ({mem_req, MisalignM, StallM, BusErrM} !== 4'b0100) begin
        errors++; $display("FAIL misalign_ctrl[%0d] got req/mis/stall/buserr=%b expected 0100",
                           i, {mem_req, MisalignM, StallM, BusErrM});
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (w_obs() !== e) begin
        errors++; $display("FAIL misalign_w[%0d] got %h expected %h", i, w_obs(), e);
      end
      $display("txn MISALIGN f3=%b addr=%h RegWriteW=%b", f3_t[i], a_t[i], RegWriteW);
    end
    @(negedge clk);
    set_idle();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (MisalignM !== 1'b0) begin
      errors++; $display("FAIL misalign_pulse got %b expected 0", MisalignM);
    end
  endtask

  task automatic test_back_to_back();
    w_t e;
    logic        rw_t [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0]  rs_t [5] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01};
    logic [2:0]  f3_t [5] = '{3'b010, 3'b010, 3'b000, 3'b101, 3'b001};
    logic [31:0] a_t  [5] = '{32'h400, 32'h404, 32'h12345, 32'h406, 32'h406};
    logic [31:0] rd_t [5] = '{32'h11223344, 32'h55667788, 32'hFFFFFFFF, 32'hBEEF1234, 32'hBEEF1234};
    logic [31:0] ex_t [5] = '{32'h11223344, 32'h55667788, 32'h0, 32'h0000BEEF, 32'hFFFFBEEF};
    logic        rq_t [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_m(rw_t[i], rs_t[i], 1'b0, f3_t[i], a_t[i], 32'h0, 5'(i + 20));
      mem_ready = 1'b1; mem_rdata = rd_t[i];
      exp_q.push_back(mk(rw_t[i], rs_t[i], ex_t[i]));
      #1;
      checks++;
      if ({mem_req, StallM} !== {rq_t[i], 1'b0}) begin
        errors++; $display("FAIL b2b_req[%0d] got req/stall=%b expected %b0", i, {mem_req, StallM}, rq_t[i]);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (w_obs() !== e) begin
        errors++; $display("FAIL b2b_w[%0d] got %h expected %h", i, w_obs(), e);
      end
      $display("txn B2B f3=%b addr=%h ReadDataW=%h", f3_t[i], a_t[i], ReadDataW);
    end
  endtask

  task automatic test_timeout();
    w_t   e;
    int   stalls;
    int   nbus;
    int   rk;
    bit   done;
    logic st;
    for (int p = 0; p < 2; p++) begin
      rk = (p == 0) ? 99 : 4;
      @(negedge clk);
      set_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h300, 32'h0, 5'd9);
      mem_ready = 1'b0; mem_rdata = 32'h5A5A0FF0;
      exp_q.push_back(mk((p == 1), 2'b01, (p == 1) ? 32'h5A5A0FF0 : 32'h0));
      stalls = 0; nbus = 0; done = 1'b0;
      for (int k = 0; k < 12 && !done; k++) begin
        if (k > 0) @(negedge clk);
        mem_ready = (k == rk);
        #1;
        st = StallM;
        if (BusErrM === 1'b1) nbus++;
        @(posedge clk); #1;
        if (st) begin
          stalls++;
          checks++;
          if ({RegWriteW, ResultSrcW} !== 3'b000) begin
            errors++; $display("FAIL to_bubble got %b expected 000", {RegWriteW, ResultSrcW});
          end
        end else begin
          done = 1'b1;
          e = exp_q.pop_front();
          checks++;
          if (w_obs() !== e) begin
            errors++; $display("FAIL to_w[%0d] got %h expected %h", p, w_obs(), e);
          end
        end
      end
      checks++;
      if (!done || stalls != 4 || nbus != ((p == 0) ? 1 : 0)) begin
        errors++; $display("FAIL to_count[%0d] got done=%0d stalls=%0d buserr=%0d expected done=1 stalls=4 buserr=%0d",
                           p, done, stalls, nbus, (p == 0) ? 1 : 0);
      end
      @(negedge clk);
      set_idle();
      mem_ready = 1'b0;
      #1;
      checks++;
      if ({mem_req, StallM, BusErrM} !== 3'b000) begin
        errors++; $display("FAIL to_after[%0d] got req/stall/buserr=%b expected 000", p, {mem_req, StallM, BusErrM});
      end
      $display("txn TIMEOUT pass=%0d stalls=%0d buserr_pulses=%0d", p, stalls, nbus);
    end
  endtask

  task automatic test_reset_wait();
    w_t e;
    @(negedge clk);
    set_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h500, 32'h0, 5'd11);
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({mem_req, StallM, mem_addr} !== {2'b11, 32'h500}) begin
      errors++; $display("FAIL rw_wait got req=%b stall=%b addr=%h expected req=1 stall=1 addr=00000500",
                         mem_req, StallM, mem_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, StallM, BusErrM, MisalignM} !== 4'b0000) begin
      errors++; $display("FAIL rw_ctrl got %b expected 0000", {mem_req, StallM, BusErrM, MisalignM});
    end
    checks++;
    if (w_obs() !== '0) begin
      errors++; $display("FAIL rw_w got %h expected %h", w_obs(), 105'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    set_idle();
    #1;
    checks++;
    if ({mem_req, StallM, BusErrM} !== 3'b000) begin
      errors++; $display("FAIL rw_idle got %b expected 000", {mem_req, StallM, BusErrM});
    end
    @(negedge clk);
    set_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h600, 32'h0, 5'd12);
    mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    exp_q.push_back(mk(1'b1, 2'b01, 32'h0BADF00D));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (w_obs() !== e) begin
      errors++; $display("FAIL rw_resume got %h expected %h", w_obs(), e);
    end
    $display("txn RESET_IN_WAIT then LW addr=00000600 ReadDataW=%h", ReadDataW);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_stall();
    test_store();
    test_misalign();
    test_back_to_back();
    test_timeout();
    test_reset_wait();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
